// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and types for the serial-port transmit path.
//   SERIAL_DATA_1_ADDR  : CPU store address of the transmit data register
//   SERIAL_STATE_1_ADDR : CPU address of the serial state word
//   TX_READY_BIT        : bit of the state word carrying txReady
//   tx_state_t          : transmit FSM states
package serial_pkg;

    localparam logic [15:0] SERIAL_DATA_1_ADDR  = 16'hBF00;
    localparam logic [15:0] SERIAL_STATE_1_ADDR = 16'hBF01;
    localparam int unsigned TX_READY_BIT        = 0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETUP,
        STROBE,
        HOLD,
        WAIT_TBRE,
        WAIT_TSRE
    } tx_state_t;

endpackage

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: synchronous byte FIFO, DEPTH entries (power of 2, >= 2).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push_i, wdata_i: write request and byte; ignored while full
//   pop_i          : remove the head entry; ignored while empty
//   head_c_o       : current head byte (combinational read)
//   full_o, empty_o: registered status, consistent with count_o
//   count_o        : number of stored entries
module serial_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [7:0]             wdata_i,
    input  logic                   pop_i,
    output logic [7:0]             head_c_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    // Accept/pop decisions use the pre-clock status.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Occupancy next state.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and status; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_c_o = mem_q[rd_ptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign count_o  = count_q;

endmodule

// File: rtl/serial_tx_writer.sv
// serial_tx_writer: queues CPU stores to the serial data address and drains
// them to the CPLD UART over the shared RAM1 data bus.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   memWrite, writeAddr,
//   writeData                   : CPU store; low byte of stores to BF00 is queued
//   txReady                     : FIFO not full (state word bit 0)
//   overflow, timeout           : sticky error flags
//   busReq, busGrant            : RAM1 bus arbitration
//   tbre, tsre                  : asynchronous UART handshake inputs
//   ram1DataOut, ram1DataDrive  : byte and tristate enable for the RAM1 bus
//   wrn                         : active-low UART write strobe
//   ram1En, ram1Oe, ram1We      : RAM1 controls, held inactive (high)
//   txCount, dropCount          : only with SERIAL_TX_STATS_EN defined
// Optional: define SERIAL_TX_STATS_EN to add the send/drop statistics counters.
module serial_tx_writer
    import serial_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memWrite,
    input  logic [15:0] writeAddr,
    input  logic [15:0] writeData,
    output logic        txReady,
    output logic        overflow,
    output logic        timeout,
    output logic        busReq,
    input  logic        busGrant,
    input  logic        tbre,
    input  logic        tsre,
    output logic [7:0]  ram1DataOut,
    output logic        ram1DataDrive,
    output logic        wrn,
    output logic        ram1En,
    output logic        ram1Oe,
    output logic        ram1We
`ifdef SERIAL_TX_STATS_EN
    ,
    output logic [15:0] txCount,
    output logic [15:0] dropCount
`endif
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SCW = (WR_LOW_CYCLES > 1) ? $clog2(WR_LOW_CYCLES) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    tx_state_t      state_q, state_d;
    logic [7:0]     byte_q, byte_d;
    logic           drive_q, drive_d;
    logic           wrn_q, wrn_d;
    logic           busreq_q, busreq_d;
    logic [SCW-1:0] strobe_cnt_q, strobe_cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           timeout_q, timeout_d;
    logic           overflow_q;
    logic           txready_q;
    logic           tbre_meta_q, tbre_sync_q;
    logic           tsre_meta_q, tsre_sync_q;
    logic           pop_c;
    logic           tx_done_c;
    logic           store_hit_c;
    logic           drop_c;
    logic [7:0]     fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           unused_wdata_hi;

    assign store_hit_c     = memWrite && (writeAddr == SERIAL_DATA_1_ADDR);
    assign drop_c          = store_hit_c && fifo_full;
    assign unused_wdata_hi = ^writeData[15:8];

    serial_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (store_hit_c),
        .wdata_i  (writeData[7:0]),
        .pop_i    (pop_c),
        .head_c_o (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    // Two-flop synchronisers for the asynchronous UART status lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbre_meta_q <= 1'b0;
            tbre_sync_q <= 1'b0;
            tsre_meta_q <= 1'b0;
            tsre_sync_q <= 1'b0;
        end else begin
            tbre_meta_q <= tbre;
            tbre_sync_q <= tbre_meta_q;
            tsre_meta_q <= tsre;
            tsre_sync_q <= tsre_meta_q;
        end
    end

    // Transmit FSM next state and registered outputs.
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        drive_d      = drive_q;
        wrn_d        = wrn_q;
        busreq_d     = busreq_q;
        strobe_cnt_d = strobe_cnt_q;
        timer_d      = timer_q;
        timeout_d    = timeout_q;
        pop_c        = 1'b0;
        tx_done_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    busreq_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (busGrant) begin
                    pop_c   = 1'b1;
                    byte_d  = fifo_head;
                    drive_d = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wrn_d        = 1'b0;
                strobe_cnt_d = '0;
                state_d      = STROBE;
            end
            STROBE: begin
                if (strobe_cnt_q == SCW'(WR_LOW_CYCLES - 1)) begin
                    wrn_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    strobe_cnt_d = strobe_cnt_q + SCW'(1);
                end
            end
            HOLD: begin
                // Release the bus so the reader can use it while the UART shifts.
                drive_d  = 1'b0;
                busreq_d = 1'b0;
                timer_d  = '0;
                state_d  = WAIT_TBRE;
            end
            WAIT_TBRE: begin
                timer_d = timer_q + TW'(1);
                if (tbre_sync_q) begin
                    state_d = WAIT_TSRE;
                end else if (timer_q >= TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_TSRE: begin
                timer_d = timer_q + TW'(1);
                if (tsre_sync_q) begin
                    tx_done_c = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q >= TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and output registers, plus status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_q       <= 8'h00;
            drive_q      <= 1'b0;
            wrn_q        <= 1'b1;
            busreq_q     <= 1'b0;
            strobe_cnt_q <= '0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            txready_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            drive_q      <= drive_d;
            wrn_q        <= wrn_d;
            busreq_q     <= busreq_d;
            strobe_cnt_q <= strobe_cnt_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_q | drop_c;
            txready_q    <= (fifo_count != CW'(FIFO_DEPTH));
        end
    end

`ifdef SERIAL_TX_STATS_EN
    logic [15:0] tx_count_q;
    logic [15:0] drop_count_q;

    // Statistics counters; wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count_q   <= 16'h0000;
            drop_count_q <= 16'h0000;
        end else begin
            if (tx_done_c) tx_count_q   <= tx_count_q + 16'(1);
            if (drop_c)    drop_count_q <= drop_count_q + 16'(1);
        end
    end

    assign txCount   = tx_count_q;
    assign dropCount = drop_count_q;
`endif

    assign txReady       = txready_q;
    assign overflow      = overflow_q;
    assign timeout       = timeout_q;
    assign busReq        = busreq_q;
    assign ram1DataOut   = byte_q;
    assign ram1DataDrive = drive_q;
    assign wrn           = wrn_q;
    assign ram1En        = 1'b1;
    assign ram1Oe        = 1'b1;
    assign ram1We        = 1'b1;

endmodule

// File: tb/tb_serial_tx_writer.sv
// tb_serial_tx_writer: directed self-checking bench for serial_tx_writer.
// Expected bytes are queued when stores are driven and popped when wrn falls.
module tb_serial_tx_writer;

    localparam int unsigned WR_LOW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        memWrite;
    logic [15:0] writeAddr;
    logic [15:0] writeData;
    logic        txReady, overflow, timeout, busReq;
    logic        busGrant, tbre, tsre;
    logic [7:0]  ram1DataOut;
    logic        ram1DataDrive, wrn, ram1En, ram1Oe, ram1We;
`ifdef SERIAL_TX_STATS_EN
    logic [15:0] txCount, dropCount;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    serial_tx_writer #(
        .FIFO_DEPTH     (4),
        .WR_LOW_CYCLES  (WR_LOW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .memWrite      (memWrite),
        .writeAddr     (writeAddr),
        .writeData     (writeData),
        .txReady       (txReady),
        .overflow      (overflow),
        .timeout       (timeout),
        .busReq        (busReq),
        .busGrant      (busGrant),
        .tbre          (tbre),
        .tsre          (tsre),
        .ram1DataOut   (ram1DataOut),
        .ram1DataDrive (ram1DataDrive),
        .wrn           (wrn),
        .ram1En        (ram1En),
        .ram1Oe        (ram1Oe),
        .ram1We        (ram1We)
`ifdef SERIAL_TX_STATS_EN
        ,
        .txCount       (txCount),
        .dropCount     (dropCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-clock store, driven just after the falling edge.
    task automatic store(input logic [15:0] addr, input logic [15:0] data);
        memWrite  = 1'b1;
        writeAddr = addr;
        writeData = data;
        @(negedge clk);
        memWrite  = 1'b0;
    endtask

    // Wait for every queued byte to be strobed, then let the handshake finish.
    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        repeat (12) @(negedge clk);
    endtask

    // Monitor: checks each strobed byte against the scoreboard and the wrn width.
    initial begin
        logic prev_wrn = 1'b1;
        int   low_cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wrn = 1'b1;
                low_cnt  = 0;
            end else begin
                if (!wrn && prev_wrn) begin
                    check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("tx_byte", 32'(ram1DataOut), 32'(exp_q.pop_front()));
                    check("drive_during_strobe", 32'(ram1DataDrive), 32'd1);
                    low_cnt = 1;
                end else if (!wrn) begin
                    low_cnt++;
                end else if (!prev_wrn) begin
                    check("wrn_low_width", 32'(low_cnt), 32'(WR_LOW));
                end
                prev_wrn = wrn;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; memWrite = 1'b0; writeAddr = '0; writeData = '0;
        busGrant = 1'b0; tbre = 1'b1; tsre = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wrn", 32'(wrn), 32'd1);
        check("rst_drive", 32'(ram1DataDrive), 32'd0);
        check("rst_data", 32'(ram1DataOut), 32'h00);
        check("rst_busreq", 32'(busReq), 32'd0);
        check("rst_txready", 32'(txReady), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_ram1_ctl", 32'({ram1En, ram1Oe, ram1We}), 32'h7);
        rst = 1'b0;
        @(negedge clk);

        // Single store, handshake delayed after HOLD.
        tbre = 1'b0; tsre = 1'b0; busGrant = 1'b1;
        exp_q.push_back(8'h34);
        store(16'hBF00, 16'h1234);
        n = 0;
        while (wrn === 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("t1_latency", 32'(n), 32'd3);
        n = 0;
        while (ram1DataDrive === 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("t1_drive_released", 32'(ram1DataDrive), 32'd0);
        check("t1_bus_released", 32'(busReq), 32'd0);
        repeat (5) @(negedge clk);
        tbre = 1'b1; tsre = 1'b1;
        drain("t1_drain");
        check("t1_wrn_idle", 32'(wrn), 32'd1);
        check("t1_txready", 32'(txReady), 32'd1);

        // Stores to other addresses are ignored.
        store(16'hBF01, 16'h00AA);
        store(16'h8000, 16'h00BB);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_no_busreq", 32'(busReq), 32'd0);
        end

        // Fill the FIFO without a grant; the fifth store is dropped.
        busGrant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'(8'h41 + i));
            store(16'hBF00, 16'(16'h0041 + i));
        end
        check("t2_txready_full", 32'(txReady), 32'd0);
        @(negedge clk);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_busreq_pending", 32'(busReq), 32'd1);
        busGrant = 1'b1;
        drain("t2_drain");
        check("t2_txready_after", 32'(txReady), 32'd1);
        check("t2_overflow_sticky", 32'(overflow), 32'd1);

        // tbre stuck low: timeout after 16 wait clocks, next byte still sent.
        tbre = 1'b0;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h66);
        store(16'hBF00, 16'h0055);
        store(16'hBF00, 16'h0066);
        n = 0;
        while (ram1DataDrive !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        while (ram1DataDrive === 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("t4_drive_released", 32'(ram1DataDrive), 32'd0);
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("t4_timeout_clocks", 32'(n), 32'd16);
        tbre = 1'b1;
        drain("t4_drain");
        check("t4_timeout_sticky", 32'(timeout), 32'd1);

        // Reset in the middle of the strobe.
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h88);
        store(16'hBF00, 16'h0077);
        store(16'hBF00, 16'h0088);
        n = 0;
        while (wrn === 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("t5_in_strobe", 32'(wrn), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_wrn", 32'(wrn), 32'd1);
        check("t5_drive", 32'(ram1DataDrive), 32'd0);
        check("t5_busreq", 32'(busReq), 32'd0);
        check("t5_txready", 32'(txReady), 32'd1);
        check("t5_flags", 32'({overflow, timeout}), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk);
        check("t5_fifo_empty", 32'(busReq), 32'd0);

        // Three successful sends followed by one drop.
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'h11 * (i + 1)));
            store(16'hBF00, 16'(16'h0011 * (i + 1)));
        end
        drain("t6_drain_sends");
        busGrant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'(8'hA1 + i));
            store(16'hBF00, 16'(16'h00A1 + i));
        end
        @(negedge clk);
        check("t6_overflow", 32'(overflow), 32'd1);
`ifdef SERIAL_TX_STATS_EN
        check("t6_txcount", 32'(txCount), 32'd3);
        check("t6_dropcount", 32'(dropCount), 32'd1);
`endif
        busGrant = 1'b1;
        drain("t6_drain_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_writer.md
Name: serial_tx_writer

Overview:
- Write-side responder for CPU stores to the serial-port data address 16'hBF00.
- Queues the low byte of each store in a small FIFO and drains it to the CPLD UART transmitter over the shared RAM1 data bus, using the wrn strobe and the tbre/tsre handshake.
- Exports a tx-ready flag for the serial-state word at 16'hBF01 (bit 0) and arbitrates for the RAM1 bus with the read-side serial controller.

Parameters:
- FIFO_DEPTH, 4: byte entries; power of 2, ≥2.
- WR_LOW_CYCLES, 2: clocks wrn is held low per byte, ≥1.
- TIMEOUT_CYCLES, 65535: max clocks spent waiting on tbre/tsre before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- memWrite  in  1  CPU store strobe, one clock per store
- writeAddr  in  16  store address
- writeData  in  16  store data; bits [7:0] are used
- txReady  out  1  FIFO not full; feeds bit 0 of the state word at BF01
- overflow  out  1  sticky: a store arrived while the FIFO was full
- timeout  out  1  sticky: a handshake wait expired
- busReq  out  1  requests the RAM1 bus
- busGrant  in  1  bus granted by the arbiter
- tbre  in  1  CPLD transmit-buffer-empty, asynchronous
- tsre  in  1  CPLD transmit-shift-empty, asynchronous
- ram1DataOut  out  8  byte driven onto the RAM1 bus
- ram1DataDrive  out  1  tristate enable for the bus; the top level builds the inout
- wrn  out  1  CPLD write strobe, active low
- ram1En, ram1Oe, ram1We  out  1 each  RAM1 controls; held high here

Behaviour:
- Reset values:
  - wrn=1, ram1En=1, ram1Oe=1, ram1We=1
  - ram1DataDrive=0, ram1DataOut=8'h00, busReq=0
  - txReady=1, overflow=0, timeout=0
  - FIFO empty, state IDLE
- Push:
  - Condition is memWrite && writeAddr==16'hBF00.
  - If the FIFO is not full, writeData[7:0] is written the same clock.
  - If the FIFO is full, the byte is dropped and overflow is set on the next clock.
  - Fullness is judged on the pre-clock count, so a push while full is dropped even if a pop happens in the same clock.
  - Stores to any other address are ignored.
- txReady = (count != FIFO_DEPTH), registered from count; it updates one clock after a push or pop.
- tbre and tsre pass through two-flop synchronisers; the FSM sees a 2-clock delay.
- FSM:
  - IDLE: if the FIFO is non-empty, set busReq=1 and go to REQ.
  - REQ: wait for busGrant. When granted, pop the FIFO head into the byte register, set ram1DataOut to the byte and ram1DataDrive=1, and go to SETUP.
  - SETUP: 1 clock, wrn=1 (data setup before the strobe).
  - STROBE: wrn=0 for WR_LOW_CYCLES clocks, then go to HOLD.
  - HOLD: 1 clock, wrn=1, data still driven. Then set ram1DataDrive=0 and busReq=0, and go to WAIT_TBRE.
  - WAIT_TBRE: wait for synced tbre=1, then go to WAIT_TSRE.
  - WAIT_TSRE: wait for synced tsre=1, then go to IDLE.
- Timeout: a counter cleared on entry to WAIT_TBRE runs through both wait states. At TIMEOUT_CYCLES it sets timeout and forces IDLE; the byte is lost.
- Bus release: the bus is given up before the wait states, so the reader can use it while the UART shifts.
- busGrant dropping while the FSM is between SETUP and HOLD is ignored. The transfer completes; the arbiter must not revoke an active grant.
- Best-case latency from push into an empty FIFO to wrn falling, with busGrant already high: 3 clocks.
- Throughput: one byte per full handshake; no overlap.
- FIFO pointers wrap modulo FIFO_DEPTH. count has log2(FIFO_DEPTH)+1 bits.
- rst mid-transfer: the state returns to IDLE immediately, wrn goes high, drive goes low, the FIFO empties and the sticky flags clear. A partially strobed byte is abandoned.

Optional Feature:
- Macro SERIAL_TX_STATS_EN.
- Defined:
  - Adds output txCount[15:0], incremented on each WAIT_TSRE→IDLE exit caused by tsre (not by timeout).
  - Adds output dropCount[15:0], incremented on each dropped push.
  - Both wrap at 16'hFFFF→0 and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is unchanged.

Decomposition:
- Package serial_pkg holds:
  - address constants SERIAL_DATA_1_ADDR=16'hBF00 and SERIAL_STATE_1_ADDR=16'hBF01
  - FSM state typedef tx_state_t: IDLE, REQ, SETUP, STROBE, HOLD, WAIT_TBRE, WAIT_TSRE
  - state-word bit index TX_READY_BIT=0
- One sub-module, serial_tx_fifo: synchronous FIFO with push, pop, full, empty and count.

Test Plan:
- Store 16'h1234 to BF00 with busGrant=1 and tbre/tsre pulsed high 5 clocks after HOLD → ram1DataOut=8'h34; wrn low exactly 2 clocks; back in IDLE; txReady=1.
- Five stores 8'h41..8'h45 back-to-back with busGrant=0 → txReady=0 after the 4th; the 5th is dropped and overflow=1. After grant, bytes 41,42,43,44 leave in order.
- Store to 16'hBF01 and to 16'h8000 → no push; busReq stays 0.
- tbre held 0 with TIMEOUT_CYCLES=16 → timeout=1 at the 16th wait clock; state IDLE; the next queued byte is still sent.
- rst asserted during STROBE → next clock wrn=1, ram1DataDrive=0, FIFO empty, all flags 0.
- With SERIAL_TX_STATS_EN, run 3 successful sends and 1 drop → txCount=3, dropCount=1.
